// File: rtl/reverb_tap_sequencer_if.sv
// Control, register and core-side signals of the reverb tap sequencer.
// The master side is the register block plus FIR core. The slave side is the sequencer.
interface reverb_tap_sequencer_if #(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16
);
  logic                       cfg_wr_en;
  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr;
  logic [G_TAP_WIDTH-1:0]     cfg_wr_data;
  logic                       cfg_wr_ready;
  logic                       user_bypass;
  logic                       load_start;
  logic                       load_busy;
  logic                       load_done;
  logic                       load_err;
  logic                       core_enable;
  logic                       core_bypass;
  logic [G_TAP_WIDTH-1:0]     tap_dout;
  logic                       tap_dout_valid;
  logic                       tap_dout_ready;
  logic                       tap_done;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, user_bypass, load_start,
           tap_dout_ready, tap_done,
    input  cfg_wr_ready, load_busy, load_done, load_err, core_enable,
           core_bypass, tap_dout, tap_dout_valid
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, user_bypass, load_start,
           tap_dout_ready, tap_done,
    output cfg_wr_ready, load_busy, load_done, load_err, core_enable,
           core_bypass, tap_dout, tap_dout_valid
  );
endinterface

// File: rtl/reverb_tap_sequencer.sv
// Reverb FIR tap-load controller. It holds a shadow tap bank and bypasses, drains and flushes the core.
// It then streams all taps into the core and waits for the core's tap_done before releasing the core.
module reverb_tap_sequencer #(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_DRAIN_CYCLES  = 8,
  parameter int G_FLUSH_CYCLES  = 2,
  parameter int G_DONE_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reverb_tap_sequencer_if.slave bus
);

  localparam int N       = 1 << G_NUM_TAPS_LOG2;
  localparam int CNT_M1  = (G_DRAIN_CYCLES > G_FLUSH_CYCLES) ? G_DRAIN_CYCLES : G_FLUSH_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > G_DONE_TIMEOUT) ? CNT_M1 : G_DONE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_UNLOADED,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_STREAM,
    S_WAIT_DONE
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [G_NUM_TAPS_LOG2-1:0] r_idx, w_idx_nxt;
  logic                       r_drain_en, w_drain_en_nxt;
  logic                       r_load_done, w_load_done_nxt;
  logic                       r_load_err, w_load_err_nxt;
  logic [G_TAP_WIDTH-1:0]     r_shadow [N];

  logic                   w_busy;
  logic                   w_wr_accept;
  logic                   w_core_enable;
  logic                   w_core_bypass;
  logic                   w_tap_valid;
  logic [G_TAP_WIDTH-1:0] w_tap_dout;

  assign w_busy      = (r_state == S_DRAIN) || (r_state == S_FLUSH) ||
                       (r_state == S_STREAM) || (r_state == S_WAIT_DONE);
  assign w_wr_accept = bus.cfg_wr_en && !w_busy;

  // NOTE: storage arrays carry no reset; clearing them would turn the bank into flops and gains nothing.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_shadow[bus.cfg_wr_addr] <= bus.cfg_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_UNLOADED;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_drain_en  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_drain_en  <= w_drain_en_nxt;
      r_load_done <= w_load_done_nxt;
      r_load_err  <= w_load_err_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_drain_en_nxt  = r_drain_en;
    w_load_done_nxt = 1'b0;
    w_load_err_nxt  = r_load_err;
    w_core_enable   = 1'b0;
    w_core_bypass   = 1'b1;
    w_tap_valid     = 1'b0;
    w_tap_dout      = '0;

    unique case (r_state)
      S_UNLOADED, S_RUN: begin
        w_core_enable = (r_state == S_RUN);
        w_core_bypass = (r_state == S_RUN) ? bus.user_bypass : 1'b1;
        if (bus.load_start) begin
          w_state_nxt    = S_DRAIN;
          w_cnt_nxt      = '0;
          w_drain_en_nxt = (r_state == S_RUN);
          w_load_err_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        // The core keeps its prior enable so samples already inside it drain out.
        w_core_enable = r_drain_en;
        if (r_cnt == CNT_W'(G_DRAIN_CYCLES - 1)) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (r_cnt == CNT_W'(G_FLUSH_CYCLES - 1)) begin
          w_state_nxt = S_STREAM;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STREAM: begin
        w_core_enable = 1'b1;
        w_tap_valid   = 1'b1;
        w_tap_dout    = r_shadow[r_idx];
        if (bus.tap_dout_ready) begin
          w_idx_nxt = r_idx + G_NUM_TAPS_LOG2'(1);
          if (r_idx == '1) begin
            w_state_nxt = S_WAIT_DONE;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        w_core_enable = 1'b1;
        if (bus.tap_done) begin
          w_state_nxt     = S_RUN;
          w_load_done_nxt = 1'b1;
        end else if (r_cnt == CNT_W'(G_DONE_TIMEOUT - 1)) begin
          w_state_nxt    = S_UNLOADED;
          w_load_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_UNLOADED;
    endcase
  end

  assign bus.cfg_wr_ready   = !w_busy;
  assign bus.load_busy      = w_busy;
  assign bus.load_done      = r_load_done;
  assign bus.load_err       = r_load_err;
  assign bus.core_enable    = w_core_enable;
  assign bus.core_bypass    = w_core_bypass;
  assign bus.tap_dout       = w_tap_dout;
  assign bus.tap_dout_valid = w_tap_valid;

endmodule

// File: tb/tb_reverb_tap_sequencer.sv
// Self-checking bench for reverb_tap_sequencer. A timeline model checks every cycle.
// Directed loads pin latency, beat order, timeout, dropped writes and reset, followed by a randomized phase.
module tb_reverb_tap_sequencer;
  localparam int NL = 4;
  localparam int N  = 16;
  localparam int TW = 16;
  localparam int D  = 8;
  localparam int F  = 2;
  localparam int T  = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  reverb_tap_sequencer_if #(.G_NUM_TAPS_LOG2(NL), .G_TAP_WIDTH(TW)) bus();

  reverb_tap_sequencer #(
    .G_NUM_TAPS_LOG2(NL), .G_TAP_WIDTH(TW),
    .G_DRAIN_CYCLES(D), .G_FLUSH_CYCLES(F), .G_DONE_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model. It tracks the age since load acceptance and a queue of pending tap beats.
  logic [TW-1:0] m_shadow [N];
  int  m_q[$];
  bit  m_busy, m_run, m_err, m_done, m_en_before;
  int  m_age, m_wait;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_run = 0; m_err = 0; m_done = 0; m_q.delete();
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.cfg_wr_en) m_shadow[bus.cfg_wr_addr] = bus.cfg_wr_data;
        if (bus.load_start) begin
          m_busy = 1; m_age = 1; m_wait = 0;
          m_en_before = m_run; m_run = 0; m_err = 0;
          m_q.delete();
          for (int i = 0; i < N; i++) m_q.push_back(int'(m_shadow[i]));
        end
      end else begin
        if (m_age > D + F) begin
          if (m_q.size() > 0) begin
            if (bus.tap_dout_ready) void'(m_q.pop_front());
          end else if (bus.tap_done) begin
            m_busy = 0; m_run = 1; m_done = 1;
          end else begin
            m_wait++;
            if (m_wait == T) begin m_busy = 0; m_err = 1; end
          end
        end
        m_age++;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle on the falling edge.
  initial forever begin
    bit exp_valid, exp_en, exp_byp;
    int exp_dout;
    @(negedge clk);
    exp_valid = m_busy && (m_age > D + F) && (m_q.size() > 0);
    exp_dout  = exp_valid ? m_q[0] : 0;
    exp_en    = !m_busy ? m_run : ((m_age <= D) ? m_en_before : ((m_age <= D + F) ? 1'b0 : 1'b1));
    exp_byp   = (!m_busy && m_run) ? bus.user_bypass : 1'b1;
    check("load_busy",      32'(bus.load_busy),      32'(m_busy));
    check("load_done",      32'(bus.load_done),      32'(m_done));
    check("load_err",       32'(bus.load_err),       32'(m_err));
    check("cfg_wr_ready",   32'(bus.cfg_wr_ready),   32'(!m_busy));
    check("core_enable",    32'(bus.core_enable),    32'(exp_en));
    check("core_bypass",    32'(bus.core_bypass),    32'(exp_byp));
    check("tap_dout_valid", 32'(bus.tap_dout_valid), 32'(exp_valid));
    check("tap_dout",       32'(bus.tap_dout),       32'(exp_dout));
    if (bus.load_done === 1'b1) done_count++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus: one driver process; step() advances one clock and refreshes per-cycle inputs.
  int ready_mode = 0;
  bit rand_on = 0;
  int latency;
  logic [TW-1:0] beat_log[$];

  task automatic step();
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.tap_done   = 1'b0;
    bus.cfg_wr_en  = 1'b0;
    case (ready_mode)
      0:       bus.tap_dout_ready = 1'b1;
      1:       bus.tap_dout_ready = ~bus.tap_dout_ready;
      default: bus.tap_dout_ready = 1'($urandom_range(0, 1));
    endcase
    if (rand_on) begin
      bus.cfg_wr_en   = ($urandom_range(0, 3) == 0);
      bus.cfg_wr_addr = NL'($urandom);
      bus.cfg_wr_data = TW'($urandom);
      if ($urandom_range(0, 7) == 0) bus.user_bypass = ~bus.user_bypass;
      bus.load_start  = ($urandom_range(0, 39) == 0);
      bus.tap_done    = ($urandom_range(0, 24) == 0);
    end
  endtask

  // A negative done_delay means tap_done is never raised.
  // If rst_at_beat is not negative, reset is asserted while that beat is presented.
  task automatic run_load(input int done_delay, input int rst_at_beat, input bit poke);
    int n;
    beat_log.delete();
    bus.load_start = 1'b1;
    step();
    n = 1;
    while (!bus.tap_dout_valid && n < 40) begin step(); n++; end
    latency = n;
    if (poke) begin
      check("wr_ready_in_stream", 32'(bus.cfg_wr_ready), 32'd0);
      bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 4'd3; bus.cfg_wr_data = 16'hBEEF;
    end
    while (bus.tap_dout_valid && n < 200) begin
      if (rst_at_beat >= 0 && beat_log.size() == rst_at_beat) begin
        reset_n = 1'b0;
        return;
      end
      if (bus.tap_dout_ready) beat_log.push_back(bus.tap_dout);
      step(); n++;
    end
    if (done_delay >= 0) begin
      repeat (done_delay - 1) step();
      bus.tap_done = 1'b1;
      step();
    end else begin
      n = 0;
      while (bus.load_busy && n < 120) begin step(); n++; end
    end
  endtask

  initial begin
    bus.cfg_wr_en = 0; bus.cfg_wr_addr = 0; bus.cfg_wr_data = 0;
    bus.user_bypass = 0; bus.load_start = 0; bus.tap_dout_ready = 1; bus.tap_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(bus.load_busy),      32'd0);
    check("rst_enable",   32'(bus.core_enable),    32'd0);
    check("rst_bypass",   32'(bus.core_bypass),    32'd1);
    check("rst_wr_ready", 32'(bus.cfg_wr_ready),   32'd1);
    check("rst_valid",    32'(bus.tap_dout_valid), 32'd0);
    check("rst_dout",     32'(bus.tap_dout),       32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < N; i++) begin
      bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = NL'(i); bus.cfg_wr_data = TW'(i + 1);
      step();
    end

    // Load with ready held high and tap_done three cycles after the last beat.
    done_count = 0;
    run_load(3, -1, 0);
    check("first_beat_latency", 32'(latency), 32'd11);
    check("beats_accepted", 32'(beat_log.size()), 32'd16);
    for (int i = 0; i < beat_log.size(); i++) check("beat_value", 32'(beat_log[i]), 32'(i + 1));
    step();
    check("done_pulses", 32'(done_count), 32'd1);
    check("run_bypass", 32'(bus.core_bypass), 32'd0);
    check("run_enable", 32'(bus.core_enable), 32'd1);

    // Load with ready toggling each cycle.
    ready_mode = 1;
    done_count = 0;
    run_load(3, -1, 0);
    check("toggle_beats", 32'(beat_log.size()), 32'd16);
    for (int i = 0; i < beat_log.size(); i++) check("toggle_beat_value", 32'(beat_log[i]), 32'(i + 1));
    step();
    check("toggle_done_pulses", 32'(done_count), 32'd1);

    // tap_done never arrives.
    ready_mode = 0;
    done_count = 0;
    run_load(-1, -1, 0);
    check("timeout_err",    32'(bus.load_err),    32'd1);
    check("timeout_busy",   32'(bus.load_busy),   32'd0);
    check("timeout_enable", 32'(bus.core_enable), 32'd0);
    check("timeout_bypass", 32'(bus.core_bypass), 32'd1);
    check("timeout_no_done", 32'(done_count),     32'd0);
    bus.load_start = 1'b1;
    step();
    check("err_cleared", 32'(bus.load_err), 32'd0);
    for (int k = 0; k < 120 && bus.load_busy; k++) step();

    // A write during STREAM is dropped, so beat 3 keeps its old value on this load and the next.
    run_load(3, -1, 1);
    check("poke_beat3", 32'(beat_log[3]), 32'd4);
    step();
    run_load(2, -1, 0);
    check("poke_dropped", 32'(beat_log[3]), 32'd4);
    step();

    // user_bypass passes straight through in RUN.
    bus.user_bypass = 1'b1; #1;
    check("ub_bypass_hi", 32'(bus.core_bypass), 32'd1);
    check("ub_enable_hi", 32'(bus.core_enable), 32'd1);
    bus.user_bypass = 1'b0; #1;
    check("ub_bypass_lo", 32'(bus.core_bypass), 32'd0);
    check("ub_enable_lo", 32'(bus.core_enable), 32'd1);
    step();

    // Reset while beat 5 is presented.
    done_count = 0;
    run_load(3, 5, 0);
    #1;
    check("mid_rst_valid",  32'(bus.tap_dout_valid), 32'd0);
    check("mid_rst_enable", 32'(bus.core_enable),    32'd0);
    check("mid_rst_busy",   32'(bus.load_busy),      32'd0);
    check("mid_rst_bypass", 32'(bus.core_bypass),    32'd1);
    step(); step();
    check("mid_rst_no_done", 32'(done_count), 32'd0);
    reset_n = 1'b1;
    step();

    // Randomized traffic checked by the model.
    ready_mode = 2;
    rand_on = 1'b1;
    repeat (3000) step();
    rand_on = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reverb_tap_sequencer.md
Name: reverb_tap_sequencer

Overview:
- Controller for the reverb FIR core: owns the core's enable, bypass and tap-load port.
- Holds a shadow tap bank written from the register interface.
- On a load command it routes audio to bypass, drains and flushes the core, streams all taps into the core, waits for the core's tap-done, then releases the core back to reverb (or user-bypass) mode.
- Sits between the control/register block and the reverb datapath wrapper.

Parameters:
G_NUM_TAPS_LOG2, 4, log2 of tap count N (equals core stages_log2 + stage_depth_log2)
G_TAP_WIDTH, 16, tap coefficient width
G_DRAIN_CYCLES, 8, cycles held in bypass before the core is disabled
G_FLUSH_CYCLES, 2, cycles core_enable is held low
G_DONE_TIMEOUT, 64, cycles allowed between last tap beat and core tap-done

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_wr_en  in  1  shadow tap write strobe
cfg_wr_addr  in  G_NUM_TAPS_LOG2  shadow tap index
cfg_wr_data  in  G_TAP_WIDTH  tap value
cfg_wr_ready  out  1  high when shadow writes are accepted
user_bypass  in  1  user bypass request
load_start  in  1  one-cycle load command
load_busy  out  1  sequence in progress
load_done  out  1  one-cycle pulse on successful completion
load_err  out  1  sticky timeout flag; cleared by next load_start
core_enable  out  1  drives core enable
core_bypass  out  1  drives core bypass
tap_dout  out  G_TAP_WIDTH  tap beat to core
tap_dout_valid  out  1  tap beat valid
tap_dout_ready  in  1  core tap ready
tap_done  in  1  core reports all taps captured

Behaviour:
- Async reset (reset_n low), outputs:
  - load_busy=0, load_done=0, load_err=0, tap_dout_valid=0, tap_dout=0
  - core_enable=0, core_bypass=1, cfg_wr_ready=1
  - state=UNLOADED
  - Shadow bank contents are not reset.
- Shadow bank:
  - Write occurs on cfg_wr_en & cfg_wr_ready.
  - cfg_wr_ready = !load_busy; writes while busy are dropped.
  - Same-cycle write and load_start: the write lands; the stream uses the new value.
- States and transitions:
  - UNLOADED: core_enable=0, core_bypass=1. load_start -> DRAIN.
  - RUN: core_enable=1, core_bypass=user_bypass (combinational pass). load_start -> DRAIN.
  - DRAIN: core_bypass=1, core_enable unchanged; count G_DRAIN_CYCLES -> FLUSH.
  - FLUSH: core_enable=0, core_bypass=1; count G_FLUSH_CYCLES -> STREAM.
  - STREAM: core_enable=1, core_bypass=1.
    - Beat index i = 0..N-1; tap_dout = shadow[i], tap_dout_valid=1.
    - Index advances on valid&ready.
    - tap_dout held stable while valid & !ready.
    - After the beat at i=N-1 is accepted: valid drops the next cycle -> WAIT_DONE.
  - WAIT_DONE: core_enable=1, core_bypass=1, timeout counter running.
    - tap_done -> RUN; load_done pulses one cycle on entry to RUN.
    - Timeout at G_DONE_TIMEOUT cycles -> UNLOADED with load_err=1.
  - Early done: tap_done seen during STREAM before the final beat is ignored (no early exit).
- load_busy=1 in DRAIN, FLUSH, STREAM and WAIT_DONE; load_start is ignored while busy.
- load_err: set on timeout; cleared on the cycle load_start is accepted.
- Latency: load_start accepted at cycle 0 -> first tap beat valid at cycle G_DRAIN_CYCLES+G_FLUSH_CYCLES+1, given ready held high.
- Min load time with ready held high: DRAIN+FLUSH+N+done latency.
- reset_n asserted mid-sequence: immediate return to UNLOADED; no load_done; the core is left disabled and bypassed.
- user_bypass change in any non-RUN state: no effect until RUN is entered.

Test Plan:
- Reset then write taps 0x0001..0x0010 (N=16), pulse load_start, ready=1, tap_done 3 cycles after last beat -> 16 beats in order; first beat at cycle 11 after load_start; load_done pulses once; core_bypass=0, core_enable=1.
- Same as above with tap_dout_ready toggling 1,0,1,0 -> beats never skipped or duplicated; tap_dout stable while stalled; 16 accepted beats total.
- tap_done never asserted -> after 64 cycles in WAIT_DONE: load_err=1, state UNLOADED, core_bypass=1, core_enable=0; next load_start clears load_err.
- cfg write to addr 3 during STREAM -> cfg_wr_ready=0, write dropped; beat 3 carries the pre-load value.
- From RUN, toggle user_bypass 0->1->0 -> core_bypass follows the same cycle; core_enable stays 1.
- reset_n pulled low during STREAM at beat 5 -> tap_dout_valid=0 and core_enable=0 immediately; load_busy=0; no load_done pulse.
